// File: rtl/mega_jsoc_oci_trace_pkg.sv
// Shared definitions for the OCI debug-trace capture path: state encoding,
// default widths and a width helper usable in constant expressions.
package mega_jsoc_oci_trace_pkg;

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_ENDED   = 2'd2
    } trace_state_t;

    localparam int DEF_DATA_W = 30;
    localparam int DEF_CNT_W  = 4;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_DROP_W = 16;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mega_jsoc_oci_trace_fifo.sv
// Trace fragment storage: circular buffer with an extra pointer bit so that
// occupancy is the plain pointer difference. overwrite_oldest advances the
// read pointer without a reader so a full buffer can keep the newest data.
module mega_jsoc_oci_trace_fifo
    import mega_jsoc_oci_trace_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_W + DEF_CNT_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      overwrite_oldest,
    input  logic [WIDTH-1:0]          wdata,
    output logic [WIDTH-1:0]          rdata,
    output logic [clog2_f(DEPTH):0]   level,
    output logic                      empty,
    output logic                      full
);

    localparam int AW = clog2_f(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Storage is not reset; rd_valid masks whatever the head holds after reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Pointer update; the read side moves on a real pop or when the oldest entry is sacrificed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop || overwrite_oldest) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mega_jsoc_cpu_oci_trace_capture.sv
// OCI debug-trace capture: qualifies fragments from the trace packer, queues
// them for the host-side unloader, accounts for lost fragments and runs the
// end-of-test flush handshake (CAPTURE -> FLUSH -> ENDED -> arm -> CAPTURE).
// Reader handshake: rd_data is offered whenever rd_valid is high and is held
// stable until the cycle rd_ready is also high, which pops it.
module mega_jsoc_cpu_oci_trace_capture
    import mega_jsoc_oci_trace_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter bit WRAP_MODE = 1'b0,
    parameter int DROP_W    = DEF_DROP_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      dct_valid,
    input  logic [DATA_W-1:0]         dct_buffer,
    input  logic [CNT_W-1:0]          dct_count,
    input  logic                      test_ending,
    input  logic                      arm,
    input  logic                      rd_ready,
    output logic                      rd_valid,
    output logic [CNT_W+DATA_W-1:0]   rd_data,
    output logic [clog2_f(DEPTH):0]   level,
    output logic                      overflow,
    output logic [DROP_W-1:0]         drop_count,
    output logic                      test_has_ended,
    output logic [1:0]                dbg_state
);

    localparam int LW = clog2_f(DEPTH) + 1;

    trace_state_t state;
    logic         fifo_empty;
    logic         fifo_full;
    logic         accept;
    logic         pop;
    logic         lost;
    logic         fifo_push;
    logic         overwrite;
    logic         flush_done;

    // Empty fragments carry no trace slots and are not treated as losses.
    assign accept     = (state == ST_CAPTURE) && dct_valid && (dct_count != '0);
    assign pop        = rd_valid && rd_ready;
    assign lost       = accept && fifo_full && !pop;
    assign fifo_push  = accept && (!fifo_full || pop || WRAP_MODE);
    assign overwrite  = lost && WRAP_MODE;
    // Nothing is written during FLUSH, so the next level is level minus any pop.
    assign flush_done = (level == '0) || ((level == LW'(1)) && pop);

    mega_jsoc_oci_trace_fifo #(
        .WIDTH (CNT_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk              (clk),
        .reset_n          (reset_n),
        .push             (fifo_push),
        .pop              (pop),
        .overwrite_oldest (overwrite),
        .wdata            ({dct_count, dct_buffer}),
        .rdata            (rd_data),
        .level            (level),
        .empty            (fifo_empty),
        .full             (fifo_full)
    );

    assign rd_valid  = !fifo_empty;
    assign dbg_state = state;

    // Capture/flush sequencing with test_has_ended registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_CAPTURE;
            test_has_ended <= 1'b0;
        end else begin
            case (state)
                ST_CAPTURE: begin
                    if (test_ending) state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (flush_done) begin
                        state          <= ST_ENDED;
                        test_has_ended <= 1'b1;
                    end
                end
                ST_ENDED: begin
                    if (arm) begin
                        state          <= ST_CAPTURE;
                        test_has_ended <= 1'b0;
                    end
                end
                default: begin
                    state          <= ST_CAPTURE;
                    test_has_ended <= 1'b0;
                end
            endcase
        end
    end

    // Loss accounting: sticky flag plus saturating counter, cleared only by arm in ENDED.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (state == ST_ENDED && arm) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (lost) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_mega_jsoc_cpu_oci_trace_capture.sv
// Directed bench: two instances (drop-on-full and wrap) share one stimulus
// stream; expected values are hand-computed constants.
module tb_mega_jsoc_cpu_oci_trace_capture;

    localparam int DATA_W = 30;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 16;
    localparam int DROP_W = 16;
    localparam int LW     = 5;
    localparam int RW     = CNT_W + DATA_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              dct_valid;
    logic [DATA_W-1:0] dct_buffer;
    logic [CNT_W-1:0]  dct_count;
    logic              test_ending;
    logic              arm;
    logic              rd_ready;

    logic              rd_valid0, rd_valid1;
    logic [RW-1:0]     rd_data0, rd_data1;
    logic [LW-1:0]     level0, level1;
    logic              overflow0, overflow1;
    logic [DROP_W-1:0] drop_count0, drop_count1;
    logic              ted0, ted1;
    logic [1:0]        state0, state1;

    int n_vec = 0;
    int n_err = 0;

    mega_jsoc_cpu_oci_trace_capture #(
        .DATA_W (DATA_W), .CNT_W (CNT_W), .DEPTH (DEPTH), .WRAP_MODE (1'b0), .DROP_W (DROP_W)
    ) dut0 (
        .clk (clk), .reset_n (reset_n), .dct_valid (dct_valid), .dct_buffer (dct_buffer),
        .dct_count (dct_count), .test_ending (test_ending), .arm (arm), .rd_ready (rd_ready),
        .rd_valid (rd_valid0), .rd_data (rd_data0), .level (level0), .overflow (overflow0),
        .drop_count (drop_count0), .test_has_ended (ted0), .dbg_state (state0)
    );

    mega_jsoc_cpu_oci_trace_capture #(
        .DATA_W (DATA_W), .CNT_W (CNT_W), .DEPTH (DEPTH), .WRAP_MODE (1'b1), .DROP_W (DROP_W)
    ) dut1 (
        .clk (clk), .reset_n (reset_n), .dct_valid (dct_valid), .dct_buffer (dct_buffer),
        .dct_count (dct_count), .test_ending (test_ending), .arm (arm), .rd_ready (rd_ready),
        .rd_valid (rd_valid1), .rd_data (rd_data1), .level (level1), .overflow (overflow1),
        .drop_count (drop_count1), .test_has_ended (ted1), .dbg_state (state1)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] frag(input logic [DATA_W-1:0] p);
        logic [CNT_W-1:0] c;
        c = 4'd4;
        return 64'({c, p});
    endfunction

    task automatic idle_inputs();
        dct_valid   = 1'b0;
        dct_buffer  = '0;
        dct_count   = '0;
        test_ending = 1'b0;
        arm         = 1'b0;
        rd_ready    = 1'b0;
    endtask

    task automatic write_frag(input logic [DATA_W-1:0] p);
        dct_valid  = 1'b1;
        dct_count  = 4'd4;
        dct_buffer = p;
        tick();
    endtask

    initial begin
        // ---- reset ----
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_valid", 64'(rd_valid0), 64'd0);
        chk("rst_level", 64'(level0), 64'd0);
        chk("rst_overflow", 64'(overflow0), 64'd0);
        chk("rst_drop", 64'(drop_count0), 64'd0);
        chk("rst_ted", 64'(ted0), 64'd0);
        chk("rst_state", 64'(state0), 64'd0);
        reset_n = 1'b1;
        tick();

        // ---- 1: three fragments, reader always ready, 1-cycle latency ----
        rd_ready = 1'b1;
        write_frag(30'h1);
        chk("t1_valid_a", 64'(rd_valid0), 64'd1);
        chk("t1_data_a", 64'(rd_data0), frag(30'h1));
        chk("t1_level_a", 64'(level0), 64'd1);
        write_frag(30'h2);
        chk("t1_data_b", 64'(rd_data0), frag(30'h2));
        chk("t1_level_b", 64'(level0), 64'd1);
        write_frag(30'h3);
        chk("t1_data_c", 64'(rd_data1), frag(30'h3));
        dct_valid = 1'b0;
        tick();
        chk("t1_drained_valid", 64'(rd_valid0), 64'd0);
        chk("t1_drained_level", 64'(level0), 64'd0);

        // ---- 2/3: 20 writes, no reads, drop vs wrap ----
        rd_ready = 1'b0;
        for (int i = 1; i <= 20; i++) write_frag(30'(i));
        dct_valid = 1'b0;
        chk("t2_level", 64'(level0), 64'd16);
        chk("t2_overflow", 64'(overflow0), 64'd1);
        chk("t2_drop", 64'(drop_count0), 64'd4);
        chk("t3_level", 64'(level1), 64'd16);
        chk("t3_overflow", 64'(overflow1), 64'd1);
        chk("t3_drop", 64'(drop_count1), 64'd4);
        rd_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("t2_entry", 64'(rd_data0), frag(30'(1 + k)));
            chk("t3_entry", 64'(rd_data1), frag(30'(5 + k)));
            tick();
        end
        chk("t2_empty", 64'(rd_valid0), 64'd0);
        chk("t3_empty", 64'(level1), 64'd0);

        // ---- 4: full with simultaneous write+pop, then empty fragments ----
        rd_ready = 1'b0;
        for (int i = 0; i < 16; i++) write_frag(30'(32'h100 + i));
        chk("t4_full", 64'(level0), 64'd16);
        rd_ready = 1'b1;
        write_frag(30'h200);
        chk("t4_level_keep", 64'(level0), 64'd16);
        chk("t4_drop_keep0", 64'(drop_count0), 64'd4);
        chk("t4_drop_keep1", 64'(drop_count1), 64'd4);
        chk("t4_head1", 64'(rd_data1), frag(30'h101));
        rd_ready  = 1'b0;
        dct_count = '0;
        dct_buffer = 30'h3FF;
        tick();
        tick();
        chk("t4_cnt0_level", 64'(level1), 64'd16);
        chk("t4_cnt0_drop", 64'(drop_count0), 64'd4);
        dct_valid = 1'b0;
        rd_ready  = 1'b1;
        repeat (15) tick();
        chk("t4_last", 64'(rd_data0), frag(30'h200));
        tick();
        chk("t4_empty", 64'(level0), 64'd0);

        // ---- 5: flush handshake and arm ----
        rd_ready = 1'b0;
        for (int i = 1; i <= 5; i++) write_frag(30'(32'h30 + i));
        dct_valid   = 1'b0;
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        chk("t5_state_flush", 64'(state0), 64'd1);
        chk("t5_level", 64'(level0), 64'd5);
        dct_valid  = 1'b1;
        dct_count  = 4'd4;
        dct_buffer = 30'h3E;
        rd_ready   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("t5_ted_low", 64'(ted0), 64'd0);
            chk("t5_read", 64'(rd_data0), frag(30'(32'h31 + k)));
            tick();
        end
        chk("t5_ted_high", 64'(ted0), 64'd1);
        chk("t5_state_ended", 64'(state1), 64'd2);
        chk("t5_no_extra", 64'(rd_valid0), 64'd0);
        tick();
        chk("t5_ended_ignore", 64'(level0), 64'd0);
        chk("t5_ovf_kept", 64'(overflow0), 64'd1);
        dct_valid = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("t5_arm_state", 64'(state0), 64'd0);
        chk("t5_arm_ted", 64'(ted0), 64'd0);
        chk("t5_arm_ovf", 64'(overflow0), 64'd0);
        chk("t5_arm_drop", 64'(drop_count1), 64'd0);

        // ---- 6: asynchronous reset during FLUSH ----
        rd_ready = 1'b0;
        for (int i = 0; i < 17; i++) write_frag(30'(32'h50 + i));
        dct_valid   = 1'b0;
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        chk("t6_pre_state", 64'(state0), 64'd1);
        chk("t6_pre_drop", 64'(drop_count0), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_state", 64'(state0), 64'd0);
        chk("t6_rst_level", 64'(level0), 64'd0);
        chk("t6_rst_valid", 64'(rd_valid1), 64'd0);
        chk("t6_rst_ovf", 64'(overflow0), 64'd0);
        chk("t6_rst_drop", 64'(drop_count1), 64'd0);
        chk("t6_rst_ted", 64'(ted0), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        write_frag(30'h77);
        dct_valid = 1'b0;
        chk("t6_resume_valid", 64'(rd_valid0), 64'd1);
        chk("t6_resume_data", 64'(rd_data0), frag(30'h77));
        chk("t6_resume_level", 64'(level0), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
